// File: rtl/pwm_duty_controller.sv
// Button-driven duty controller: synchronises and debounces up/down keys, auto-repeats while held,
// and stages a saturating duty value that reaches the PWM generator only at a period boundary.
module pwm_duty_controller #(
    parameter int DUTY_W       = 8,
    parameter int DUTY_RST     = 128,
    parameter int DEB_CYCLES   = 16,
    parameter int REPEAT_DELAY = 256,
    parameter int REPEAT_RATE  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              xu,
    input  logic              xd,
    input  logic [2:0]        conf,
    input  logic              period_end,
    output logic [DUTY_W-1:0] duty,
    output logic              pending,
    output logic              at_max,
    output logic              at_min
);

    localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DUTY_W-1:0] DUTY_MAX   = '1;
    localparam logic [DUTY_W-1:0] DUTY_INIT  = DUTY_W'(DUTY_RST);
    localparam logic [DEB_W-1:0]  DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
    localparam logic [RPT_W-1:0]  DELAY_LOAD = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0]  RATE_LOAD  = RPT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {S_IDLE, S_FIRST, S_HOLD, S_REPEAT} state_e;
    typedef logic [DUTY_W:0] ext_t;

    // Bit 0 carries the up key, bit 1 the down key.
    logic [1:0]       meta_q, sync_q, level_q, level_d;
    logic [DEB_W-1:0] deb_cnt_q [2];
    logic [DEB_W-1:0] deb_cnt_d [2];

    state_e           state_q, state_d;
    logic             dir_q, dir_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             step, abort;

    logic [DUTY_W-1:0] shadow_q, shadow_d, duty_q, duty_d, stepped;
    logic              pending_q, pending_d, at_max_q, at_max_d, at_min_q, at_min_d;
    ext_t              step_amt, sum, diff;

    // NOTE: every flop, including the debounce counter array, sits on the async reset so
    // the block leaves reset in a known state without needing a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q    <= '0;
            sync_q    <= '0;
            level_q   <= '0;
            deb_cnt_q <= '{default: '0};
        end else begin
            // NOTE: non-blocking assignments make meta_q -> sync_q a genuine two-stage chain.
            meta_q    <= {xd, xu};
            sync_q    <= meta_q;
            level_q   <= level_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    always_comb begin
        // NOTE: defaults up front guarantee every path assigns, so no latches are inferred.
        level_d   = level_q;
        deb_cnt_d = deb_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync_q[i] == level_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
                deb_cnt_d[i] = '0;
                level_d[i]   = ~level_q[i];
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            dir_q     <= 1'b0;
            rpt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

    assign abort = ~ena | (dir_q ? (~level_q[0] | level_q[1]) : (~level_q[1] | level_q[0]));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (ena && (level_q[0] ^ level_q[1])) state_d = S_FIRST;
            S_FIRST:  state_d = S_HOLD;
            S_HOLD:   if (abort) state_d = S_IDLE;
                      else if (rpt_cnt_q == RPT_W'(1)) state_d = S_REPEAT;
            S_REPEAT: if (abort) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // HOLD runs the counter down to zero; REPEAT then steps whenever it sits at zero.
    always_comb begin
        step      = 1'b0;
        dir_d     = dir_q;
        rpt_cnt_d = rpt_cnt_q;
        case (state_q)
            S_IDLE:  dir_d = level_q[0];
            S_FIRST: begin
                step      = 1'b1;
                rpt_cnt_d = DELAY_LOAD;
            end
            S_HOLD:  if (!abort) rpt_cnt_d = rpt_cnt_q - RPT_W'(1);
            S_REPEAT: begin
                if (!abort) begin
                    if (rpt_cnt_q == '0) begin
                        step      = 1'b1;
                        rpt_cnt_d = RATE_LOAD;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q - RPT_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        if (int'(conf) > DUTY_W - 1) step_amt = ext_t'(1) << (DUTY_W - 1);
        else                         step_amt = ext_t'(1) << conf;
        sum  = {1'b0, shadow_q} + step_amt;
        diff = {1'b0, shadow_q} - step_amt;
        if (dir_q) stepped = sum[DUTY_W]  ? DUTY_MAX : sum[DUTY_W-1:0];
        else       stepped = diff[DUTY_W] ? '0       : diff[DUTY_W-1:0];
    end

    // A transfer publishes the pre-edge shadow; a simultaneous step re-arms pending.
    always_comb begin
        shadow_d  = shadow_q;
        duty_d    = duty_q;
        pending_d = pending_q;
        if (period_end && pending_q) begin
            duty_d    = shadow_q;
            pending_d = 1'b0;
        end
        if (step && (stepped != shadow_q)) begin
            shadow_d  = stepped;
            pending_d = 1'b1;
        end
        at_max_d = (shadow_d == DUTY_MAX);
        at_min_d = (shadow_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q  <= DUTY_INIT;
            duty_q    <= DUTY_INIT;
            pending_q <= 1'b0;
            at_max_q  <= (DUTY_INIT == DUTY_MAX);
            at_min_q  <= (DUTY_INIT == '0);
        end else begin
            shadow_q  <= shadow_d;
            duty_q    <= duty_d;
            pending_q <= pending_d;
            at_max_q  <= at_max_d;
            at_min_q  <= at_min_d;
        end
    end

    assign duty    = duty_q;
    assign pending = pending_q;
    assign at_max  = at_max_q;
    assign at_min  = at_min_q;

endmodule

// File: tb/tb_pwm_duty_controller.sv
// Scoreboard bench for pwm_duty_controller: expected duty values are queued as keys are driven
// and popped by a monitor whenever the published duty changes.
module tb_pwm_duty_controller;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       xu;
    logic       xd;
    logic [2:0] conf;
    logic       period_end;
    logic [7:0] duty;
    logic       pending;
    logic       at_max;
    logic       at_min;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int sb[$];
    int chg_cyc[$];
    int press_cyc;
    int pend_hits;
    logic [7:0] prev_duty = '0;

    pwm_duty_controller #(
        .DUTY_W      (8),
        .DUTY_RST    (128),
        .DEB_CYCLES  (4),
        .REPEAT_DELAY(20),
        .REPEAT_RATE (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .xu        (xu),
        .xd        (xd),
        .conf      (conf),
        .period_end(period_end),
        .duty      (duty),
        .pending   (pending),
        .at_max    (at_max),
        .at_min    (at_min)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Every change of the published duty must match the next queued expectation.
    always @(negedge clk) begin
        if (rst) begin
            prev_duty = duty;
        end else if (duty !== prev_duty) begin
            chg_cyc.push_back(cyc);
            if (sb.size() == 0) check("duty_unexpected", duty, prev_duty);
            else                check("duty_sb", duty, sb.pop_front());
            prev_duty = duty;
        end
    end

    task automatic press(input logic up, input logic [2:0] c);
        conf = c;
        @(posedge clk); #1;
        if (up) xu = 1'b1;
        else    xd = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        xu = 1'b0;
        xd = 1'b0;
        repeat (14) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; ena = 1'b1; xu = 1'b0; xd = 1'b0; conf = 3'd0; period_end = 1'b0;

        // Async reset before any clock edge
        #2 rst = 1'b1;
        #1;
        check("rst0_duty", duty, 128);
        check("rst0_pending", pending, 0);
        check("rst0_at_max", at_max, 0);
        check("rst0_at_min", at_min, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Single clean step, held back until period_end
        conf = 3'd0;
        @(posedge clk); #1 xu = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("s1_pend_before_step", pending, 0);
        @(posedge clk);
        @(negedge clk);
        check("s1_pend_at_step", pending, 1);
        check("s1_duty_held", duty, 128);
        repeat (2) @(posedge clk);
        #1 xu = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("s1_duty_wait", duty, 128);
        check("s1_pend_wait", pending, 1);
        sb.push_back(129);
        period_end = 1'b1;
        @(posedge clk);
        #1 period_end = 1'b0;
        check("s1_duty_xfer", duty, 129);
        check("s1_pend_clear", pending, 0);

        // Mid-stream reset with a staged value outstanding
        press(1'b1, 3'd0);
        check("mr_pend_staged", pending, 1);
        check("mr_duty_staged", duty, 129);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        check("mr_duty", duty, 128);
        check("mr_pending", pending, 0);
        check("mr_at_max", at_max, 0);
        check("mr_at_min", at_min, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Bouncing key must never produce a step
        period_end = 1'b1;
        for (int i = 0; i < 15; i++) begin
            xu = ~xu;
            repeat (2) @(posedge clk);
            #1;
        end
        xu = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("bounce_duty", duty, 128);
        check("bounce_pend", pending, 0);

        // Auto-repeat with saturation, period_end every cycle
        chg_cyc.delete();
        conf = 3'd5;
        sb.push_back(160); sb.push_back(192); sb.push_back(224); sb.push_back(255);
        pend_hits = 0;
        @(posedge clk); #1 xu = 1'b1;
        press_cyc = cyc;
        for (int i = 1; i <= 75; i++) begin
            @(posedge clk); #1;
            if (i == 60) xu = 1'b0;
            if (i >= 41 && i <= 65 && pending) pend_hits++;
        end
        check("rep_changes", chg_cyc.size(), 4);
        if (chg_cyc.size() >= 4) begin
            check("rep_first_latency", chg_cyc[0] - press_cyc, 9);
            check("rep_delay_gap", chg_cyc[1] - chg_cyc[0], 21);
            check("rep_rate_gap1", chg_cyc[2] - chg_cyc[1], 5);
            check("rep_rate_gap2", chg_cyc[3] - chg_cyc[2], 5);
        end
        check("rep_duty", duty, 255);
        check("rep_at_max", at_max, 1);
        check("rep_at_min", at_min, 0);
        check("rep_sat_pend_hits", pend_hits, 0);

        // Both keys together: no step
        do_reset();
        check("rst2_at_max", at_max, 0);
        conf = 3'd0;
        @(posedge clk); #1;
        xu = 1'b1; xd = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        xu = 1'b0; xd = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("both_duty", duty, 128);
        check("both_pend", pending, 0);

        // ena dropped during auto-repeat freezes stepping
        sb.push_back(129); sb.push_back(130); sb.push_back(131);
        @(posedge clk); #1 xu = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (i == 36) ena = 1'b0;
        end
        xu = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("freeze_duty", duty, 131);
        check("freeze_pend", pending, 0);

        // A staged value still transfers while ena is low
        period_end = 1'b0;
        ena = 1'b1;
        press(1'b1, 3'd0);
        ena = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("ena0_pend_staged", pending, 1);
        check("ena0_duty_held", duty, 131);
        sb.push_back(132);
        period_end = 1'b1;
        @(posedge clk);
        #1 period_end = 1'b0;
        check("ena0_duty_xfer", duty, 132);
        check("ena0_pend_clear", pending, 0);
        ena = 1'b1;

        // Walk down to 16, then clamp to the floor
        do_reset();
        period_end = 1'b1;
        sb.push_back(64);
        press(1'b0, 3'd6);
        sb.push_back(32);
        press(1'b0, 3'd5);
        sb.push_back(16);
        press(1'b0, 3'd4);
        check("floor_start", duty, 16);
        sb.push_back(0);
        press(1'b0, 3'd7);
        check("floor_duty", duty, 0);
        check("floor_at_min", at_min, 1);
        check("floor_at_max", at_max, 0);
        period_end = 1'b0;
        press(1'b0, 3'd7);
        check("floor_again_duty", duty, 0);
        check("floor_again_pend", pending, 0);
        check("floor_again_at_min", at_min, 1);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
